// File: rtl/multi_slot_scheduler.sv
// Time-of-day scheduler: NUM_SLOTS programmable hh:mm entries, each firing a
// retriggerable fixed-length run pulse on one of 2**DEV_W device outputs.
module multi_slot_scheduler #(
  parameter int NUM_SLOTS  = 4,
  parameter int DEV_W      = 2,
  parameter int RUN_CYCLES = 16,
  localparam int ND = 2 ** DEV_W,
  localparam int SW = $clog2(NUM_SLOTS),
  localparam int CW = $clog2(RUN_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       hour,
  input  logic [5:0]       minute,
  input  logic             global_en,
  input  logic             cfg_we,
  input  logic [SW-1:0]    cfg_slot,
  input  logic             cfg_valid,
  input  logic [4:0]       cfg_hour,
  input  logic [5:0]       cfg_minute,
  input  logic [DEV_W-1:0] cfg_dev,
  output logic             cfg_err,
  output logic [ND-1:0]    dev_run,
  output logic             fire,
  output logic [SW-1:0]    fire_slot,
  output logic             collision
);

  logic [NUM_SLOTS-1:0] slot_valid;
  logic [4:0]           slot_hour   [NUM_SLOTS];
  logic [5:0]           slot_minute [NUM_SLOTS];
  logic [DEV_W-1:0]     slot_dev    [NUM_SLOTS];
  logic [CW-1:0]        cnt         [ND];
  logic [10:0]          time_q;
  logic                 init;

  logic                 tick;
  logic                 cfg_bad;
  logic [NUM_SLOTS-1:0] trig;
  logic [ND-1:0]        dev_hit;
  logic                 coll_next;
  logic [SW-1:0]        first_slot;

  // A trigger only happens on the cycle the presented time differs from last cycle's.
  assign tick    = !init && global_en && ({hour, minute} != time_q);
  assign cfg_bad = (cfg_hour > 5'd23) || (cfg_minute > 6'd59);

  always_comb begin
    trig = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      trig[i] = tick && slot_valid[i] && (slot_hour[i] == hour) && (slot_minute[i] == minute);
    end
  end

  // Devices hit twice in one tick, or hit while still running, count as a collision.
  always_comb begin
    dev_hit    = '0;
    coll_next  = 1'b0;
    first_slot = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (trig[i]) first_slot = SW'(i);
    end
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (trig[i]) begin
        if (dev_hit[slot_dev[i]] || (cnt[slot_dev[i]] != '0)) coll_next = 1'b1;
        dev_hit[slot_dev[i]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_valid <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_hour[i]   <= '0;
        slot_minute[i] <= '0;
        slot_dev[i]    <= '0;
      end
    end else if (cfg_we && !cfg_bad) begin
      slot_valid[cfg_slot]  <= cfg_valid;
      slot_hour[cfg_slot]   <= cfg_hour;
      slot_minute[cfg_slot] <= cfg_minute;
      slot_dev[cfg_slot]    <= cfg_dev;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_q    <= '0;
      init      <= 1'b1;
      fire      <= 1'b0;
      fire_slot <= '0;
      collision <= 1'b0;
      cfg_err   <= 1'b0;
      for (int d = 0; d < ND; d++) cnt[d] <= '0;
    end else begin
      time_q    <= {hour, minute};
      init      <= 1'b0;
      fire      <= |trig;
      fire_slot <= first_slot;
      collision <= coll_next;
      cfg_err   <= cfg_we && cfg_bad;
      for (int d = 0; d < ND; d++) begin
        if (dev_hit[d])         cnt[d] <= CW'(RUN_CYCLES);
        else if (!global_en)    cnt[d] <= '0;
        else if (cnt[d] != '0)  cnt[d] <= cnt[d] - CW'(1);
      end
    end
  end

  always_comb begin
    dev_run = '0;
    for (int d = 0; d < ND; d++) dev_run[d] = (cnt[d] != '0);
  end

endmodule

// File: tb/tb_multi_slot_scheduler.sv
// Directed scenarios plus randomized traffic for multi_slot_scheduler, checked
// every cycle against a slot/time/remaining-run reference model.
module tb_multi_slot_scheduler;
  localparam int NUM_SLOTS  = 4;
  localparam int DEV_W      = 2;
  localparam int RUN_CYCLES = 16;
  localparam int ND         = 4;
  localparam int SW         = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       hour;
  logic [5:0]       minute;
  logic             global_en;
  logic             cfg_we;
  logic [SW-1:0]    cfg_slot;
  logic             cfg_valid;
  logic [4:0]       cfg_hour;
  logic [5:0]       cfg_minute;
  logic [DEV_W-1:0] cfg_dev;
  logic             cfg_err;
  logic [ND-1:0]    dev_run;
  logic             fire;
  logic [SW-1:0]    fire_slot;
  logic             collision;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit v;
    int h;
    int m;
    int d;
  } slot_t;

  slot_t m_slot [NUM_SLOTS];
  int    m_rem  [ND];
  int    m_tq;
  bit    m_init;
  bit    e_fire, e_coll, e_err;
  int    e_slot;

  always #5 clk = ~clk;

  multi_slot_scheduler #(.NUM_SLOTS(NUM_SLOTS), .DEV_W(DEV_W), .RUN_CYCLES(RUN_CYCLES)) dut (
    .clk(clk), .rst(rst), .hour(hour), .minute(minute), .global_en(global_en),
    .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_valid(cfg_valid), .cfg_hour(cfg_hour),
    .cfg_minute(cfg_minute), .cfg_dev(cfg_dev), .cfg_err(cfg_err), .dev_run(dev_run),
    .fire(fire), .fire_slot(fire_slot), .collision(collision)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NUM_SLOTS; i++) m_slot[i] = '{0, 0, 0, 0};
    for (int d = 0; d < ND; d++) m_rem[d] = 0;
    m_tq = 0; m_init = 1; e_fire = 0; e_coll = 0; e_err = 0; e_slot = 0;
  endtask

  // Applies the scheduling rules to the inputs currently presented, for one rising edge.
  task automatic modelEdge();
    int cur;
    bit tick;
    int hits [ND];
    cur  = int'(hour) * 64 + int'(minute);
    tick = !m_init && global_en && (cur != m_tq);
    for (int d = 0; d < ND; d++) hits[d] = 0;
    e_fire = 0; e_coll = 0; e_slot = 0;
    if (tick) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (m_slot[i].v && m_slot[i].h == int'(hour) && m_slot[i].m == int'(minute)) begin
          if (!e_fire) e_slot = i;
          e_fire = 1;
          hits[m_slot[i].d]++;
        end
      end
    end
    for (int d = 0; d < ND; d++) begin
      if (hits[d] > 0) begin
        if (hits[d] > 1 || m_rem[d] > 0) e_coll = 1;
        m_rem[d] = RUN_CYCLES;
      end else if (!global_en) m_rem[d] = 0;
      else if (m_rem[d] > 0) m_rem[d] = m_rem[d] - 1;
    end
    e_err = cfg_we && (int'(cfg_hour) > 23 || int'(cfg_minute) > 59);
    if (cfg_we && !e_err)
      m_slot[int'(cfg_slot)] = '{cfg_valid, int'(cfg_hour), int'(cfg_minute), int'(cfg_dev)};
    m_tq   = cur;
    m_init = 0;
  endtask

  function automatic logic [ND-1:0] expRun();
    logic [ND-1:0] r;
    for (int d = 0; d < ND; d++) r[d] = (m_rem[d] > 0);
    return r;
  endfunction

  task automatic checkAll(input string tag);
    checkOutput({tag, "_run"}, 32'(dev_run), 32'(expRun()));
    checkOutput({tag, "_fire"}, 32'(fire), 32'(e_fire));
    checkOutput({tag, "_coll"}, 32'(collision), 32'(e_coll));
    checkOutput({tag, "_err"}, 32'(cfg_err), 32'(e_err));
    if (e_fire) checkOutput({tag, "_slot"}, 32'(fire_slot), 32'(e_slot));
  endtask

  task automatic step(input string tag);
    if (rst) begin
      @(posedge clk);
      #1;
      modelReset();
    end else begin
      modelEdge();
      @(posedge clk);
      #1;
    end
    checkAll(tag);
  endtask

  task automatic applyStimulus(input int h, input int m, input bit en, input string tag);
    hour = 5'(h); minute = 6'(m); global_en = en;
    step(tag);
  endtask

  task automatic writeSlot(input int s, input bit v, input int h, input int m, input int d);
    cfg_slot = SW'(s); cfg_valid = v; cfg_hour = 5'(h); cfg_minute = 6'(m); cfg_dev = DEV_W'(d);
    cfg_we = 1'b1;
    step("cfg");
    cfg_we = 1'b0;
  endtask

  task automatic asyncReset(input string tag);
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput({tag, "_async_run"}, 32'(dev_run), 32'(0));
    step(tag);
    rst = 1'b0;
  endtask

  initial begin
    int hi, nf;
    rst = 1'b1; hour = 0; minute = 0; global_en = 1; cfg_we = 0;
    cfg_slot = 0; cfg_valid = 0; cfg_hour = 0; cfg_minute = 0; cfg_dev = 0;
    modelReset();
    #2;
    checkAll("reset");
    step("reset");
    rst = 1'b0;

    // Single slot fires once and runs for RUN_CYCLES cycles.
    applyStimulus(7, 29, 1, "t1_pre");
    writeSlot(0, 1, 7, 30, 1);
    applyStimulus(7, 30, 1, "t1_hit");
    checkOutput("t1_fire", 32'(fire), 32'(1));
    checkOutput("t1_devrun", 32'(dev_run), 32'(4'b0010));
    hi = 1; nf = 0;
    for (int k = 0; k < 100; k++) begin
      applyStimulus(7, 30, 1, "t1_hold");
      hi += int'(dev_run[1]);
      nf += int'(fire);
    end
    checkOutput("t1_high", 32'(hi), 32'(RUN_CYCLES));
    checkOutput("t2_refire", 32'(nf), 32'(0));

    // Reset while the current time already equals a slot time.
    asyncReset("t2_rst");
    writeSlot(0, 1, 7, 30, 1);
    nf = 0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(7, 30, 1, "t2_hold");
      nf += int'(fire);
    end
    checkOutput("t2_nofire", 32'(nf), 32'(0));

    // Two slots targeting the same device on the same tick.
    writeSlot(0, 1, 10, 0, 3);
    writeSlot(2, 1, 10, 0, 3);
    applyStimulus(9, 59, 1, "t3_pre");
    applyStimulus(10, 0, 1, "t3_hit");
    checkOutput("t3_coll", 32'(collision), 32'(1));
    checkOutput("t3_slot", 32'(fire_slot), 32'(0));
    checkOutput("t3_devrun", 32'(dev_run), 32'(4'b1000));
    for (int k = 0; k < 20; k++) applyStimulus(10, 0, 1, "t3_drain");

    // Retrigger of a running device extends its run.
    writeSlot(1, 1, 11, 0, 2);
    writeSlot(3, 1, 11, 5, 2);
    applyStimulus(11, 0, 1, "t4_hit");
    hi = int'(dev_run[2]);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(11, 0, 1, "t4_run");
      hi += int'(dev_run[2]);
    end
    applyStimulus(11, 5, 1, "t4_retrig");
    checkOutput("t4_coll", 32'(collision), 32'(1));
    checkOutput("t4_slot", 32'(fire_slot), 32'(3));
    hi += int'(dev_run[2]);
    for (int k = 0; k < 30; k++) begin
      applyStimulus(11, 5, 1, "t4_tail");
      hi += int'(dev_run[2]);
    end
    checkOutput("t4_high", 32'(hi), 32'(11 + RUN_CYCLES));

    // Rejected write, then a write on the same edge as a tick.
    writeSlot(1, 1, 24, 0, 0);
    checkOutput("t5_err", 32'(cfg_err), 32'(1));
    applyStimulus(10, 59, 1, "t5_pre");
    applyStimulus(11, 0, 1, "t5_keep");
    checkOutput("t5_keepslot", 32'(fire_slot), 32'(1));
    writeSlot(0, 1, 12, 0, 0);
    applyStimulus(11, 59, 1, "t5_pre2");
    hour = 12; minute = 0;
    cfg_slot = 0; cfg_valid = 0; cfg_hour = 12; cfg_minute = 0; cfg_dev = 0;
    cfg_we = 1'b1;
    step("t5_tickwr");
    cfg_we = 1'b0;
    checkOutput("t5_old", 32'(fire), 32'(1));
    applyStimulus(12, 0, 1, "t5_still");
    checkOutput("t5_running", 32'(dev_run[0]), 32'(1));

    // Disable mid-run, ignore time changes, then wrap to midnight.
    applyStimulus(12, 0, 0, "t6_dis");
    checkOutput("t6_cleared", 32'(dev_run), 32'(0));
    applyStimulus(11, 0, 0, "t6_ign");
    applyStimulus(11, 0, 1, "t6_reen");
    checkOutput("t6_nofire", 32'(fire), 32'(0));
    writeSlot(2, 1, 0, 0, 1);
    applyStimulus(23, 59, 1, "t6_pre");
    applyStimulus(0, 0, 1, "t6_wrap");
    checkOutput("t6_wrapfire", 32'(fire), 32'(1));
    checkOutput("t6_wrapslot", 32'(fire_slot), 32'(2));

    // Randomized traffic over a small time window so slots match often.
    for (int k = 0; k < 800; k++) begin
      int h, m;
      h = ($urandom_range(0, 15) == 0) ? int'($urandom_range(24, 31)) : int'($urandom_range(0, 2));
      m = ($urandom_range(0, 15) == 0) ? int'($urandom_range(60, 63)) : int'($urandom_range(0, 3));
      if ($urandom_range(0, 150) == 0) asyncReset("rnd_rst");
      if ($urandom_range(0, 4) == 0) begin
        cfg_we     = 1'b1;
        cfg_slot   = SW'($urandom_range(0, NUM_SLOTS - 1));
        cfg_valid  = 1'($urandom_range(0, 3) != 0);
        cfg_hour   = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 2));
        cfg_minute = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(60, 63)) : 6'($urandom_range(0, 3));
        cfg_dev    = DEV_W'($urandom_range(0, ND - 1));
      end
      applyStimulus(h, m, 1'($urandom_range(0, 9) != 0), "rnd");
      cfg_we = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
